sng_stream: RTL and testbench

Stochastic number generator stage sitting directly downstream of the 8-bit maximal-length LFSR.
- Accepts a binary operand plus an LFSR seed over a valid/ready handshake.
- Seeds the LFSR, then emits a 2^N−1-bit stochastic bitstream where bit = (lfsr_data <= value), and counts the ones.
- Returns the ones count over a second valid/ready handshake.
- Feeds the stochastic-computing datapath and provides a self-checking count for the LFSR/SNG pair.

---
 rtl/sng_stream.sv | 104 ++++++++++
 tb/tb_sng_stream.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sng_stream.sv
// sng_stream: stochastic number generator stage fed by an external
// maximal-length LFSR. It accepts an operand and a seed, seeds the LFSR,
// then emits a LEN-bit stochastic bitstream (bit = lfsr_data <= value) and
// counts the ones. The count is returned over a result handshake.
module sng_stream #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_value,
    input  logic [N-1:0] in_seed,
    output logic         lfsr_load_seed,
    output logic [N-1:0] lfsr_seed,
    input  logic [N-1:0] lfsr_data,
    output logic         bit_valid,
    output logic         bit_out,
    output logic         bit_last,
    output logic         res_valid,
    output logic [N-1:0] res_ones,
    input  logic         res_ready
);

    localparam int LEN = (2 ** N) - 1;
    localparam logic [N-1:0] K_LAST = N'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t       state;
    logic [N-1:0] value_q;
    logic [N-1:0] seed_q;
    logic [N-1:0] k;
    logic [N-1:0] seed_nz;
    logic         stoch_bit;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign seed_nz   = (in_seed == '0) ? N'(1) : in_seed;
    assign stoch_bit = (lfsr_data <= value_q);
    assign in_ready  = (state == IDLE);

    // Job sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            value_q        <= '0;
            seed_q         <= '0;
            k              <= '0;
            lfsr_load_seed <= 1'b0;
            lfsr_seed      <= '0;
            bit_valid      <= 1'b0;
            bit_out        <= 1'b0;
            bit_last       <= 1'b0;
            res_valid      <= 1'b0;
            res_ones       <= '0;
        end else begin
            lfsr_load_seed <= 1'b0;
            bit_valid      <= 1'b0;
            bit_out        <= 1'b0;
            bit_last       <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        value_q        <= in_value;
                        seed_q         <= seed_nz;
                        lfsr_seed      <= seed_nz;
                        lfsr_load_seed <= 1'b1;
                        res_ones       <= '0;
                        k              <= '0;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    lfsr_seed <= seed_q;
                    state     <= RUN;
                end
                RUN: begin
                    bit_out   <= stoch_bit;
                    bit_valid <= 1'b1;
                    bit_last  <= (k == K_LAST);
                    res_ones  <= res_ones + N'(stoch_bit);
                    k         <= k + N'(1);
                    if (k == K_LAST) begin
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sng_stream.sv
// Testbench for sng_stream: an 8-bit maximal LFSR environment, a driver that
// issues jobs and pushes the expected stream/result into queues, and a
// monitor that pops and compares whenever the DUT presents output.
module tb_sng_stream;

    localparam int N   = 8;
    localparam int LEN = 255;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_value = '0;
    logic [N-1:0] in_seed = '0;
    logic         lfsr_load_seed;
    logic [N-1:0] lfsr_seed;
    logic [N-1:0] lfsr_data;
    logic         bit_valid;
    logic         bit_out;
    logic         bit_last;
    logic         res_valid;
    logic [N-1:0] res_ones;
    logic         res_ready = 1'b1;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic         bit_exp[$];
    logic         last_exp[$];
    logic [N-1:0] seed_exp[$];
    logic [N-1:0] res_exp[$];

    int hs_cyc = 0;

    sng_stream #(.N(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_value      (in_value),
        .in_seed       (in_seed),
        .lfsr_load_seed(lfsr_load_seed),
        .lfsr_seed     (lfsr_seed),
        .lfsr_data     (lfsr_data),
        .bit_valid     (bit_valid),
        .bit_out       (bit_out),
        .bit_last      (bit_last),
        .res_valid     (res_valid),
        .res_ones      (res_ones),
        .res_ready     (res_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Maximal polynomial x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form.
    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // LFSR environment the DUT drives.
    always @(posedge clk or negedge reset) begin
        if (!reset)              lfsr_data <= 8'h01;
        else if (lfsr_load_seed) lfsr_data <= lfsr_seed;
        else                     lfsr_data <= lfsr_step(lfsr_data);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the stream visits the LFSR sequence from the seed;
    // the ones count is the operand itself.
    task automatic push_job(input logic [N-1:0] v, input logic [N-1:0] s);
        logic [N-1:0] st;
        st = (s == 0) ? 8'h01 : s;
        seed_exp.push_back(st);
        for (int i = 0; i < LEN; i++) begin
            bit_exp.push_back(st <= v);
            last_exp.push_back(i == LEN - 1);
            st = lfsr_step(st);
        end
        res_exp.push_back(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_load_seed"}, int'(lfsr_load_seed), 0);
        chk({tag, "_lfsr_seed"}, int'(lfsr_seed), 0);
        chk({tag, "_bit_valid"}, int'(bit_valid), 0);
        chk({tag, "_bit_out"}, int'(bit_out), 0);
        chk({tag, "_bit_last"}, int'(bit_last), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_res_ones"}, int'(res_ones), 0);
    endtask

    task automatic wait_accept(output int acc_cyc);
        bit ok;
        ok = 0;
        acc_cyc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_res_valid();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("res_valid_timeout", 0, 1);
    endtask

    task automatic wait_drained();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (res_exp.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_in_valid(input string name);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_value = N'($urandom_range(0, 255));
        @(negedge clk);
        chk(name, int'(in_ready), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [N-1:0] v, input logic [N-1:0] s, input int stall);
        int acc;
        push_job(v, s);
        res_ready = (stall == 0);
        in_valid  = 1'b1;
        in_value  = v;
        in_seed   = s;
        wait_accept(acc);
        in_valid  = 1'b0;
        if (stall > 0) begin
            wait_res_valid();
            repeat (stall) @(negedge clk);
            @(posedge clk); #1;
            res_ready = 1'b1;
        end
        wait_drained();
    endtask

    // Monitor: pops expectations whenever the DUT presents output.
    initial begin : monitor
        int  acc_cyc;
        int  pulses;
        bit  first_bit_pend;
        bit  res_pend;
        acc_cyc = 0;
        pulses = 0;
        first_bit_pend = 0;
        res_pend = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pulses = 0;
                first_bit_pend = 0;
                res_pend = 0;
            end else begin
                if (in_valid && in_ready) begin
                    acc_cyc = cyc;
                    first_bit_pend = 1;
                    res_pend = 1;
                end
                if (lfsr_load_seed) begin
                    chk("load_latency", cyc - acc_cyc, 1);
                    if (seed_exp.size() == 0) chk("spurious_load", 1, 0);
                    else chk("lfsr_seed", int'(lfsr_seed), int'(seed_exp.pop_front()));
                end
                if (bit_valid) begin
                    if (first_bit_pend) begin
                        chk("first_bit_latency", cyc - acc_cyc, 3);
                        first_bit_pend = 0;
                    end
                    if (bit_exp.size() == 0) chk("spurious_bit", 1, 0);
                    else begin
                        chk("bit_out", int'(bit_out), int'(bit_exp.pop_front()));
                        chk("bit_last", int'(bit_last), int'(last_exp.pop_front()));
                    end
                    pulses++;
                end
                if (res_valid) begin
                    if (res_pend) begin
                        chk("res_latency", cyc - acc_cyc, LEN + 2);
                        res_pend = 0;
                    end
                    if (res_exp.size() == 0) chk("spurious_res", 1, 0);
                    else begin
                        chk("res_ones", int'(res_ones), int'(res_exp[0]));
                        if (res_ready) begin
                            void'(res_exp.pop_front());
                            chk("bit_pulses", pulses, LEN);
                            pulses = 0;
                            hs_cyc = cyc;
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        int a1, a2;
        #2;
        check_reset_outputs("por");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_job(8'd128, 8'h01, 0);
        run_job(8'h00, 8'hA5, 0);
        run_job(8'hFF, 8'hA5, 0);
        run_job(8'd77, 8'h00, 0);
        run_job(8'd77, 8'h01, 0);

        // Stalled result with ignored in_valid pulses during RUN and DONE.
        push_job(8'd99, 8'h3C);
        res_ready = 1'b0;
        in_valid  = 1'b1;
        in_value  = 8'd99;
        in_seed   = 8'h3C;
        wait_accept(a1);
        in_valid  = 1'b0;
        repeat (10) @(posedge clk);
        pulse_in_valid("busy_run_in_ready");
        pulse_in_valid("busy_run_in_ready");
        wait_res_valid();
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 2) pulse_in_valid("busy_done_in_ready");
            @(negedge clk);
            chk("stall_res_valid", int'(res_valid), 1);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_drained();

        // Abort a job at RUN k=100.
        push_job(8'd150, 8'h5A);
        in_valid = 1'b1;
        in_value = 8'd150;
        in_seed  = 8'h5A;
        wait_accept(a1);
        in_valid = 1'b0;
        repeat (101) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        bit_exp.delete();
        last_exp.delete();
        seed_exp.delete();
        res_exp.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_job(8'd37, 8'($urandom_range(0, 255)), 0);

        // Back-to-back jobs with in_valid held high.
        push_job(8'd10, 8'h11);
        push_job(8'd200, 8'h11);
        res_ready = 1'b1;
        in_valid  = 1'b1;
        in_value  = 8'd10;
        in_seed   = 8'h11;
        wait_accept(a1);
        in_value  = 8'd200;
        wait_accept(a2);
        in_valid  = 1'b0;
        chk("b2b_accept_gap", a2 - hs_cyc, 1);
        chk("b2b_period", a2 - a1, LEN + 3);
        wait_drained();

        // Randomized jobs with random result stalls.
        for (int j = 0; j < 6; j++) begin
            run_job(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    int'($urandom_range(0, 6)));
        end

        chk("queues_drained", bit_exp.size() + seed_exp.size() + res_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
